// File: rtl/da_lms_pkg.sv
// Shared types, width helpers and arithmetic helpers
// for the bit-serial DA-LMS adaptive filter.
`timescale 1ns/1ps
package da_lms_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, ACC, UPDATE} state_t;

   localparam int TAPS_DEF = 4;
   localparam int XW_DEF   = 8;
   localparam int WW_DEF   = 8;
   localparam int DW_DEF   = 10;

   function automatic int lut_w(input int taps, input int xw);
      return xw + $clog2(taps);
   endfunction

   function automatic int acc_w(input int taps, input int xw,
                                input int ww);
      return xw + ww + $clog2(taps) + 1;
   endfunction

   function automatic int upd_w(input int xw, input int dw);
      return xw + dw;
   endfunction

   localparam int LUTW = lut_w(TAPS_DEF, XW_DEF);
   localparam int ACCW = acc_w(TAPS_DEF, XW_DEF, WW_DEF);
   localparam int UPDW = upd_w(XW_DEF, DW_DEF);

   // clamp a wide signed value into a w-bit signed range
   function automatic logic signed [63:0] sat(
      input logic signed [63:0] v, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // position of the most significant set bit (0 when v==0)
   function automatic int lead_one(input logic [63:0] v);
      int q;
      q = 0;
      for (int i = 0; i < 64; i++)
         if (v[i]) q = i;
      return q;
   endfunction

endpackage

// File: rtl/da_partial_lut.sv
// Partial-sum table: entry a holds the sum of the taps
// selected by the set bits of a, built one entry per cycle.
`timescale 1ns/1ps
module da_partial_lut
   import da_lms_pkg::*;
#(
   parameter int TAPS = TAPS_DEF,
   parameter int XW   = XW_DEF,
   parameter int LW   = LUTW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [TAPS-1:0]      idx,
   input  logic [TAPS*XW-1:0]   taps,
   input  logic [TAPS-1:0]      addr,
   output logic signed [LW-1:0] data
);

   localparam int N = 2 ** TAPS;

   logic signed [LW-1:0] lut [N];
   logic signed [XW-1:0] t;
   logic [TAPS-1:0]      base;

   function automatic int ctz(input logic [TAPS-1:0] a);
      int c;
      c = 0;
      for (int i = TAPS - 1; i >= 0; i--)
         if (a[i]) c = i;
      return c;
   endfunction

   // entry a reuses a with its lowest set bit removed
   always_comb begin
      base = idx & (idx - TAPS'(1));
      t    = taps[ctz(idx)*XW +: XW];
   end

   // incremental table build, entry 0 stays zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) lut[i] <= '0;
      end else if (load) begin
         lut[idx] <= lut[base] + LW'(t);
      end
   end

   assign data = lut[addr];

endmodule

// File: rtl/da_lms_serial_filter.sv
// Bit-serial distributed-arithmetic LMS FIR filter with
// power-of-two sign-error weight adaptation.
`timescale 1ns/1ps
module da_lms_serial_filter
   import da_lms_pkg::*;
#(
   parameter int TAPS     = TAPS_DEF,
   parameter int XW       = XW_DEF,
   parameter int WW       = WW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MU_SHIFT = 2,
   parameter int X_SHIFT  = XW - 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XW-1:0]        x_in,
   input  logic [DW-1:0]        d_in,
   input  logic                 adapt_en,
   input  logic                 wt_clear,
   output logic                 out_valid,
   output logic [DW-1:0]        y_out,
   output logic [DW-1:0]        err_out,
   output logic [TAPS*WW-1:0]   weights_out
);

   localparam int LW = lut_w(TAPS, XW);
   localparam int AW = acc_w(TAPS, XW, WW);
   localparam int UW = upd_w(XW, DW);
   localparam int BW = $clog2(WW);
   localparam logic [TAPS-1:0] LAST = '1;

   state_t               state;
   logic signed [XW-1:0] tap [TAPS];
   logic signed [WW-1:0] w   [TAPS];
   logic signed [WW-1:0] w_n [TAPS];
   logic signed [DW-1:0] d_q;
   logic                 ae_q;
   logic [TAPS-1:0]      lidx;
   logic [BW-1:0]        bidx;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] term;
   logic [TAPS*XW-1:0]   tap_flat;
   logic [TAPS-1:0]      addr;
   logic signed [LW-1:0] lut_q;
   logic signed [DW-1:0] y_n, e_n, es;
   logic signed [63:0]   mag;
   logic signed [UW-1:0] dl;
   int                   q;

   assign in_ready = (state == IDLE);

   da_partial_lut #(.TAPS(TAPS), .XW(XW), .LW(LW)) u_lut (
      .clk  (clk),
      .rst  (rst),
      .load (state == LOAD),
      .idx  (lidx),
      .taps (tap_flat),
      .addr (addr),
      .data (lut_q)
   );

   // flatten taps, slice weight bit-plane, expose weights
   always_comb begin
      tap_flat    = '0;
      addr        = '0;
      weights_out = '0;
      for (int k = 0; k < TAPS; k++) begin
         tap_flat[k*XW +: XW]    = tap[k];
         addr[k]                 = w[k][bidx];
         weights_out[k*WW +: WW] = w[k];
      end
      term = AW'(lut_q);
      if (bidx == BW'(WW - 1)) term = -term;
   end

   // output, error and sign-error weight update terms
   always_comb begin
      y_n = DW'(sat(64'(acc >>> (WW - 1)), DW));
      e_n = DW'(sat(64'(d_q) - 64'(y_n), DW));
      es  = e_n >>> MU_SHIFT;
      mag = es[DW-1] ? -64'(es) : 64'(es);
      q   = lead_one(mag);
      dl  = '0;
      for (int k = 0; k < TAPS; k++) begin
         dl = (UW'(tap[k]) <<< q) >>> X_SHIFT;
         if (es[DW-1]) dl = -dl;
         w_n[k] = WW'(sat(64'(w[k]) + 64'(dl), WW));
         if (!ae_q || es == '0) w_n[k] = w[k];
      end
   end

   // sequencer: accept, build table, serial MAC, update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         lidx      <= '0;
         bidx      <= '0;
         acc       <= '0;
         d_q       <= '0;
         ae_q      <= 1'b0;
         y_out     <= '0;
         err_out   <= '0;
         out_valid <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            tap[k] <= '0;
            w[k]   <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  tap[0] <= x_in;
                  for (int k = 1; k < TAPS; k++)
                     tap[k] <= tap[k-1];
                  d_q   <= d_in;
                  ae_q  <= adapt_en;
                  lidx  <= TAPS'(1);
                  state <= LOAD;
               end else if (wt_clear) begin
                  for (int k = 0; k < TAPS; k++) w[k] <= '0;
               end
            end
            LOAD: begin
               if (lidx == LAST) begin
                  acc   <= '0;
                  bidx  <= BW'(WW - 1);
                  state <= ACC;
               end else begin
                  lidx <= lidx + TAPS'(1);
               end
            end
            ACC: begin
               acc <= (acc <<< 1) + term;
               if (bidx == '0) state <= UPDATE;
               else            bidx  <= bidx - BW'(1);
            end
            UPDATE: begin
               y_out     <= y_n;
               err_out   <= e_n;
               out_valid <= 1'b1;
               for (int k = 0; k < TAPS; k++) w[k] <= w_n[k];
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_da_lms_serial_filter.sv
// Directed self-checking bench for da_lms_serial_filter
// using default parameters.
`timescale 1ns/1ps
module tb_da_lms_serial_filter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        adapt_en = 1'b0;
   logic        wt_clear = 1'b0;
   logic [7:0]  x_in = 8'd0;
   logic [9:0]  d_in = 10'd0;
   logic        in_ready, out_valid;
   logic [9:0]  y_out, err_out;
   logic [31:0] weights_out;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   da_lms_serial_filter dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x_in        (x_in),
      .d_in        (d_in),
      .adapt_en    (adapt_en),
      .wt_clear    (wt_clear),
      .out_valid   (out_valid),
      .y_out       (y_out),
      .err_out     (err_out),
      .weights_out (weights_out)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_sample(input logic [7:0] x, input logic [9:0] d,
                             input logic ae, input int clr_at,
                             output int lat);
      @(negedge clk);
      x_in = x; d_in = d; adapt_en = ae; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; x_in = 8'h55; d_in = 10'h155; adapt_en = ~ae;
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         wt_clear = (lat == clr_at);
         if (out_valid) break;
      end
      wt_clear = 1'b0;
      if (!out_valid) begin
         tests++; fails++;
         $display("FAIL sample_timeout: no out_valid after %0d cycles", lat);
      end
   endtask

   task automatic test_reset();
      #12;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: ready=%b valid=%b need 1/0", in_ready, out_valid);
      end
      tests++;
      if (y_out !== 10'd0 || err_out !== 10'd0 || weights_out !== 32'd0) begin
         fails++;
         $display("FAIL reset_data: y=%h e=%h w=%h need 0", y_out, err_out, weights_out);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_frozen();
      int lat;
      run_sample(8'd10, 10'd40, 1'b0, -1, lat);
      tests++;
      if (lat !== 24) begin
         fails++; $display("FAIL latency: got %0d need 24", lat);
      end
      tests++;
      if (y_out !== 10'd0 || err_out !== 10'd40 || weights_out !== 32'd0) begin
         fails++;
         $display("FAIL frozen: y=%0d e=%0d w=%h need 0 40 0", y_out, err_out, weights_out);
      end
   endtask

   task automatic test_adapt();
      int lat;
      do_reset();
      run_sample(8'd64, 10'd64, 1'b1, -1, lat);
      tests++;
      if (y_out !== 10'd0 || err_out !== 10'd64 || weights_out !== 32'h0000_0008) begin
         fails++;
         $display("FAIL adapt1: y=%0d e=%0d w=%h need 0 64 00000008", y_out, err_out, weights_out);
      end
      run_sample(8'd64, 10'd64, 1'b1, -1, lat);
      tests++;
      if (y_out !== 10'd4 || err_out !== 10'd60 || weights_out !== 32'h0000_040C) begin
         fails++;
         $display("FAIL adapt2: y=%0d e=%0d w=%h need 4 60 0000040c", y_out, err_out, weights_out);
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      @(negedge clk);
      x_in = 8'd50; d_in = 10'd7; adapt_en = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1 || weights_out !== 32'd0 || y_out !== 10'd0) begin
         fails++;
         $display("FAIL reset_mid: ready=%b w=%h y=%0d need 1 0 0", in_ready, weights_out, y_out);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++; $display("FAIL abort_pulse: out_valid=%b need 0", seen);
      end
   endtask

   task automatic test_sat_pos();
      int  lat;
      logic neg;
      neg = 1'b0;
      for (int i = 0; i < 60; i++) begin
         run_sample(8'd127, 10'd511, 1'b1, -1, lat);
         if (weights_out[7] | weights_out[15] | weights_out[23] | weights_out[31])
            neg = 1'b1;
      end
      tests++;
      if (neg !== 1'b0) begin
         fails++; $display("FAIL sat_wrap: negative weight seen=%b need 0", neg);
      end
      tests++;
      if (weights_out !== 32'h7F7F_7F7F || y_out !== 10'd504 || err_out !== 10'd7) begin
         fails++;
         $display("FAIL sat_pos: w=%h y=%0d e=%0d need 7f7f7f7f 504 7", weights_out, y_out, err_out);
      end
   endtask

   task automatic test_clear_in_acc();
      int lat;
      run_sample(8'd127, 10'd0, 1'b0, 18, lat);
      tests++;
      if (weights_out !== 32'h7F7F_7F7F || y_out !== 10'd504 || err_out !== 10'h208) begin
         fails++;
         $display("FAIL clear_acc: w=%h y=%0d e=%h need 7f7f7f7f 504 208", weights_out, y_out, err_out);
      end
   endtask

   task automatic test_clear_idle();
      int lat;
      @(negedge clk);
      wt_clear = 1'b1;
      @(posedge clk);
      #1 wt_clear = 1'b0;
      tests++;
      if (weights_out !== 32'd0) begin
         fails++; $display("FAIL clear_idle: w=%h need 0", weights_out);
      end
      run_sample(8'd127, 10'd64, 1'b1, -1, lat);
      tests++;
      if (weights_out !== 32'h0F0F_0F0F || y_out !== 10'd0 || err_out !== 10'd64) begin
         fails++;
         $display("FAIL taps_kept: w=%h y=%0d e=%0d need 0f0f0f0f 0 64", weights_out, y_out, err_out);
      end
   endtask

   task automatic test_sat_neg();
      int lat;
      do_reset();
      for (int i = 0; i < 40; i++)
         run_sample(8'h80, 10'd511, 1'b1, -1, lat);
      tests++;
      if (weights_out !== 32'h8480_8080 || y_out !== 10'd508 || err_out !== 10'd3) begin
         fails++;
         $display("FAIL neg_conv: w=%h y=%0d e=%0d need 84808080 508 3", weights_out, y_out, err_out);
      end
      run_sample(8'h80, 10'd0, 1'b0, -1, lat);
      run_sample(8'h00, 10'd0, 1'b0, -1, lat);
      run_sample(8'h00, 10'd0, 1'b0, -1, lat);
      run_sample(8'h00, 10'd511, 1'b1, -1, lat);
      tests++;
      if (weights_out !== 32'h8080_8080 || y_out !== 10'd124 || err_out !== 10'd387) begin
         fails++;
         $display("FAIL w_floor: w=%h y=%0d e=%0d need 80808080 124 387", weights_out, y_out, err_out);
      end
      repeat (4) run_sample(8'h80, 10'd0, 1'b0, -1, lat);
      tests++;
      if (y_out !== 10'd511 || err_out !== 10'h201) begin
         fails++; $display("FAIL y_sat: y=%h e=%h need 1ff 201", y_out, err_out);
      end
      run_sample(8'h80, 10'h200, 1'b0, -1, lat);
      tests++;
      if (y_out !== 10'd511 || err_out !== 10'h200) begin
         fails++; $display("FAIL e_sat: y=%h e=%h need 1ff 200", y_out, err_out);
      end
   endtask

   task automatic test_back_to_back();
      int  t[$];
      logic ov_ok;
      int  n;
      ov_ok = 1'b1;
      @(negedge clk);
      x_in = 8'd3; d_in = 10'd0; adapt_en = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 90; c++) begin
         if (in_ready) begin
            if (t.size() > 0 && out_valid !== 1'b1) ov_ok = 1'b0;
            t.push_back(c);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests++;
      if (t.size() !== 4) begin
         fails++; $display("FAIL b2b_count: accepts=%0d need 4", t.size());
      end
      for (int i = 1; i < t.size(); i++) begin
         tests++;
         if (t[i] - t[i-1] !== 25) begin
            fails++;
            $display("FAIL b2b_gap: gap %0d = %0d need 25", i, t[i] - t[i-1]);
         end
      end
      tests++;
      if (ov_ok !== 1'b1) begin
         fails++; $display("FAIL b2b_overlap: out_valid not high at re-accept");
      end
      n = 0;
      while (n < 40 && !in_ready) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL b2b_drain: ready=%b need 1", in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_frozen();
      test_adapt();
      test_reset_mid();
      test_sat_pos();
      test_clear_in_acc();
      test_clear_idle();
      test_sat_neg();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
